// File: rtl/pipe_scroller_pkg.sv
// Shared definitions for the pipe scroller and its neighbours.
// Holds the screen and coordinate widths, the default pipe geometry and
// the control state encoding.
package pipe_scroller_pkg;

  localparam int SCREEN_W  = 640;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int NUM_PIPES = 4;

  // Score comparisons are done one bit wider than X so that x + PIPE_W
  // can never wrap around.
  localparam int CMP_W     = 12;

  localparam int         DEF_X0        = SCREEN_W;
  localparam int         DEF_SPACING   = 160;
  localparam int         DEF_SPEED     = 2;
  localparam int         DEF_PIPE_W    = 40;
  localparam int         DEF_BIRD_X    = 160;
  localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_scroller_if.sv
// Signal bundle between the pipe scroller and its environment.
// slave  : the scroller (consumes frame/start/collide and ROM heights,
//          produces ROM index, pipe positions, score and running flags).
// master : the environment side (game control, height ROM, renderer).
interface pipe_scroller_if;
  import pipe_scroller_pkg::*;

  logic           frame_tick_i;
  logic           start_i;
  logic           collide_i;
  logic [1:0]     rom_idx_o;
  logic [Y_W-1:0] rom_y0_i;
  logic [Y_W-1:0] rom_y1_i;
  logic [Y_W-1:0] rom_y2_i;
  logic [Y_W-1:0] rom_y3_i;
  logic [X_W-1:0] pipe_x0_o;
  logic [X_W-1:0] pipe_x1_o;
  logic [X_W-1:0] pipe_x2_o;
  logic [X_W-1:0] pipe_x3_o;
  logic [Y_W-1:0] pipe_y0_o;
  logic [Y_W-1:0] pipe_y1_o;
  logic [Y_W-1:0] pipe_y2_o;
  logic [Y_W-1:0] pipe_y3_o;
  logic           score_o;
  logic           running_o;

  modport master (
    output frame_tick_i, start_i, collide_i,
    output rom_y0_i, rom_y1_i, rom_y2_i, rom_y3_i,
    input  rom_idx_o,
    input  pipe_x0_o, pipe_x1_o, pipe_x2_o, pipe_x3_o,
    input  pipe_y0_o, pipe_y1_o, pipe_y2_o, pipe_y3_o,
    input  score_o, running_o
  );

  modport slave (
    input  frame_tick_i, start_i, collide_i,
    input  rom_y0_i, rom_y1_i, rom_y2_i, rom_y3_i,
    output rom_idx_o,
    output pipe_x0_o, pipe_x1_o, pipe_x2_o, pipe_x3_o,
    output pipe_y0_o, pipe_y1_o, pipe_y2_o, pipe_y3_o,
    output score_o, running_o
  );

endinterface

// File: rtl/pipe_scroller_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4), advancing one step
// per clock while en_i is high and holding otherwise.
// Ports: clk, rst_n (async, active-low, loads SEED), en_i, lfsr_o (state).
// SEED must be non-zero or the register locks up at all zeros.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: obstacle manager sitting downstream of the pipe-height ROM.
// Drives the ROM index from an LFSR, latches the four returned heights while
// idle, scrolls four pipes left by SPEED on every frame tick while running,
// respawns a pipe at the right edge of the ring when it leaves the screen and
// pulses score_o when a pipe's trailing edge clears the bird column.
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   bus.frame_tick_i    : one-cycle pulse per video frame
//   bus.start_i         : start (IDLE->RUN) / restart (HALT->IDLE)
//   bus.collide_i       : collision flag, stops the game
//   bus.rom_idx_o       : height ROM index (LFSR low bits)
//   bus.rom_y0..3_i     : ROM heights (primary, edge1, edge2, edge3)
//   bus.pipe_x0..3_o    : pipe left-edge X
//   bus.pipe_y0..3_o    : pipe top-edge Y
//   bus.score_o         : one-cycle pulse per pipe passed
//   bus.running_o       : high while in RUN
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int         X0        = DEF_X0,
  parameter int         SPACING   = DEF_SPACING,
  parameter int         SPEED     = DEF_SPEED,
  parameter int         PIPE_W    = DEF_PIPE_W,
  parameter int         BIRD_X    = DEF_BIRD_X,
  parameter logic [7:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input logic            Clk,
  input logic            Reset_n,
  pipe_scroller_if.slave bus
);

  localparam logic [X_W-1:0]   SPEED_X    = X_W'(SPEED);
  // A wrapping pipe jumps one full ring of pipes to the right, so the pitch
  // to its neighbours is unchanged.
  localparam logic [X_W-1:0]   WRAP_ADD_X = X_W'(NUM_PIPES * SPACING - SPEED);
  localparam logic [CMP_W-1:0] PIPE_W_C   = CMP_W'(PIPE_W);
  localparam logic [CMP_W-1:0] BIRD_X_C   = CMP_W'(BIRD_X);

  state_e         state_q;
  state_e         state_d;
  logic [X_W-1:0] pipe_x_q [NUM_PIPES];
  logic [X_W-1:0] pipe_x_d [NUM_PIPES];
  logic [Y_W-1:0] pipe_y_q [NUM_PIPES];
  logic [Y_W-1:0] pipe_y_d [NUM_PIPES];
  logic [Y_W-1:0] rom_y    [NUM_PIPES];
  logic           score_q;
  logic           score_d;
  logic           running_q;
  logic           running_d;
  logic           lfsr_en;
  logic [7:0]     lfsr_w;
  logic           unused_lfsr_hi;

  function automatic logic [X_W-1:0] layout_x(input int k);
    return X_W'(X0 + k * SPACING);
  endfunction

  // True when the pipe's right edge moves from at/right of the bird column
  // to strictly left of it.
  function automatic logic clears_bird(input logic [X_W-1:0] old_x,
                                       input logic [X_W-1:0] new_x);
    logic [CMP_W-1:0] old_r;
    logic [CMP_W-1:0] new_r;
    old_r = CMP_W'(old_x) + PIPE_W_C;
    new_r = CMP_W'(new_x) + PIPE_W_C;
    return (old_r >= BIRD_X_C) && (new_r < BIRD_X_C);
  endfunction

  assign rom_y[0] = bus.rom_y0_i;
  assign rom_y[1] = bus.rom_y1_i;
  assign rom_y[2] = bus.rom_y2_i;
  assign rom_y[3] = bus.rom_y3_i;

  // The sequence only advances during play, so restarting from HALT reloads
  // the heights seen at the frozen index.
  assign lfsr_en = (state_q == RUN);

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .en_i   (lfsr_en),
    .lfsr_o (lfsr_w)
  );

  assign unused_lfsr_hi = ^lfsr_w[7:2];

  always_comb begin
    state_d = state_q;
    score_d = 1'b0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      pipe_x_d[k] = pipe_x_q[k];
      pipe_y_d[k] = pipe_y_q[k];
    end

    case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_PIPES; k++) begin
          pipe_x_d[k] = layout_x(k);
          pipe_y_d[k] = rom_y[k];
        end
        if (bus.start_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // A collision in the same cycle as a tick suppresses the move.
        if (bus.collide_i) begin
          state_d = HALT;
        end else if (bus.frame_tick_i) begin
          for (int k = 0; k < NUM_PIPES; k++) begin
            if (pipe_x_q[k] >= SPEED_X) begin
              pipe_x_d[k] = pipe_x_q[k] - SPEED_X;
              if (clears_bird(pipe_x_q[k], pipe_x_q[k] - SPEED_X)) begin
                score_d = 1'b1;
              end
            end else begin
              pipe_x_d[k] = pipe_x_q[k] + WRAP_ADD_X;
              pipe_y_d[k] = bus.rom_y0_i;
            end
          end
        end
      end

      HALT: begin
        if (bus.start_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      score_q   <= 1'b0;
      running_q <= 1'b0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        pipe_x_q[k] <= layout_x(k);
        pipe_y_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      running_q <= running_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        pipe_x_q[k] <= pipe_x_d[k];
        pipe_y_q[k] <= pipe_y_d[k];
      end
    end
  end

  assign bus.rom_idx_o = lfsr_w[1:0];
  assign bus.pipe_x0_o = pipe_x_q[0];
  assign bus.pipe_x1_o = pipe_x_q[1];
  assign bus.pipe_x2_o = pipe_x_q[2];
  assign bus.pipe_x3_o = pipe_x_q[3];
  assign bus.pipe_y0_o = pipe_y_q[0];
  assign bus.pipe_y1_o = pipe_y_q[1];
  assign bus.pipe_y2_o = pipe_y_q[2];
  assign bus.pipe_y3_o = pipe_y_q[3];
  assign bus.score_o   = score_q;
  assign bus.running_o = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Testbench for pipe_scroller with a small height ROM attached.
module tb_pipe_scroller;

  localparam int X0      = 640;
  localparam int SPACING = 160;
  localparam int SPEED   = 2;
  localparam int PIPE_W  = 40;
  localparam int BIRD_X  = 160;
  localparam int RING    = 4 * SPACING;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic Clk = 1'b0;
  logic Reset_n;

  pipe_scroller_if bus();

  pipe_scroller dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Height ROM: four heights, outputs rotated by the index.
  function automatic logic [9:0] rom_h(input logic [1:0] i);
    return 10'(100 + 50 * int'(i));
  endfunction

  assign bus.rom_y0_i = rom_h(bus.rom_idx_o);
  assign bus.rom_y1_i = rom_h(bus.rom_idx_o + 2'd1);
  assign bus.rom_y2_i = rom_h(bus.rom_idx_o + 2'd2);
  assign bus.rom_y3_i = rom_h(bus.rom_idx_o + 2'd3);

  logic [10:0] ox [4];
  logic [9:0]  oy [4];
  assign ox[0] = bus.pipe_x0_o;
  assign ox[1] = bus.pipe_x1_o;
  assign ox[2] = bus.pipe_x2_o;
  assign ox[3] = bus.pipe_x3_o;
  assign oy[0] = bus.pipe_y0_o;
  assign oy[1] = bus.pipe_y1_o;
  assign oy[2] = bus.pipe_y2_o;
  assign oy[3] = bus.pipe_y3_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: positions are a closed form of the tick count since
  // the layout load; heights and the LFSR are tracked per clock.
  int         m_state;
  int         m_ticks;
  logic [7:0] m_lfsr;
  logic [9:0] m_y [4];
  logic       m_score;

  function automatic int pos(input int k, input int n);
    int v;
    v = X0 + k * SPACING - SPEED * n;
    if (v < 0) v = ((v % RING) + RING) % RING;
    return v;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_ticks = 0;
    m_lfsr  = 8'hA5;
    m_score = 1'b0;
    for (int k = 0; k < 4; k++) m_y[k] = '0;
  endtask

  // Drive one clock of inputs and advance the model across that edge.
  task automatic cycle(input logic tick, input logic collide, input logic start);
    int old_x;
    int new_x;
    bus.frame_tick_i = tick;
    bus.collide_i    = collide;
    bus.start_i      = start;
    m_score = 1'b0;
    case (m_state)
      M_IDLE: begin
        m_ticks = 0;
        for (int k = 0; k < 4; k++) m_y[k] = rom_h(m_lfsr[1:0] + 2'(k));
        if (start) m_state = M_RUN;
      end
      M_RUN: begin
        if (collide) begin
          m_state = M_HALT;
        end else if (tick) begin
          m_ticks++;
          for (int k = 0; k < 4; k++) begin
            old_x = pos(k, m_ticks - 1);
            new_x = pos(k, m_ticks);
            if (old_x < SPEED) m_y[k] = rom_h(m_lfsr[1:0]);
            else if (old_x + PIPE_W >= BIRD_X && new_x + PIPE_W < BIRD_X) m_score = 1'b1;
          end
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
      default: begin
        if (start) m_state = M_IDLE;
      end
    endcase
    @(posedge Clk);
    #1;
    bus.frame_tick_i = 1'b0;
    bus.collide_i    = 1'b0;
    bus.start_i      = 1'b0;
  endtask

  task automatic test_reset();
    int exp_y [4] = '{150, 200, 250, 100};
    Reset_n = 1'b0;
    bus.frame_tick_i = 1'b0;
    bus.collide_i    = 1'b0;
    bus.start_i      = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ox[k] !== 11'(X0 + k * SPACING)) $display("FAIL reset_x%0d: got %0d exp %0d", k, ox[k], X0 + k * SPACING);
      else n_pass++;
      n_checks++;
      if (oy[k] !== 10'd0) $display("FAIL reset_y%0d: got %0d exp 0", k, oy[k]);
      else n_pass++;
    end
    n_checks++;
    if (bus.score_o !== 1'b0 || bus.running_o !== 1'b0)
      $display("FAIL reset_flags: score %b running %b exp 0 0", bus.score_o, bus.running_o);
    else n_pass++;
    n_checks++;
    if (bus.rom_idx_o !== 2'b01) $display("FAIL reset_idx: got %0d exp 1", bus.rom_idx_o);
    else n_pass++;

    Reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (oy[k] !== 10'(exp_y[k])) $display("FAIL idle_y%0d: got %0d exp %0d", k, oy[k], exp_y[k]);
      else n_pass++;
      n_checks++;
      if (ox[k] !== 11'(X0 + k * SPACING)) $display("FAIL idle_x%0d: got %0d exp %0d", k, ox[k], X0 + k * SPACING);
      else n_pass++;
    end
    n_checks++;
    if (bus.running_o !== 1'b0) $display("FAIL idle_running: got %b exp 0", bus.running_o);
    else n_pass++;
  endtask

  task automatic test_scroll();
    int pulses;
    int pulse_tick;
    pulses = 0;
    pulse_tick = 0;
    cycle(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.running_o !== 1'b1) $display("FAIL start_running: got %b exp 1", bus.running_o);
    else n_pass++;
    for (int t = 1; t <= 261; t++) begin
      repeat ($urandom_range(0, 2)) begin
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.score_o !== 1'b0) $display("FAIL gap_score before tick %0d: got 1 exp 0", t);
        else n_pass++;
      end
      cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.score_o !== m_score) $display("FAIL scroll_score tick %0d: got %b exp %b", t, bus.score_o, m_score);
      else n_pass++;
      if (bus.score_o === 1'b1) begin
        pulses++;
        pulse_tick = t;
      end
    end
    n_checks++;
    if (pulses !== 1 || pulse_tick !== 261)
      $display("FAIL score_pulses: got %0d pulses last at tick %0d exp 1 at tick 261", pulses, pulse_tick);
    else n_pass++;
    n_checks++;
    if (ox[0] !== 11'd118) $display("FAIL scroll_x0: got %0d exp 118", ox[0]);
    else n_pass++;
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (ox[k] !== 11'(pos(k, m_ticks))) $display("FAIL scroll_x%0d: got %0d exp %0d", k, ox[k], pos(k, m_ticks));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    for (int t = 262; t <= 321; t++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.score_o !== m_score) $display("FAIL wrap_score tick %0d: got %b exp %b", t, bus.score_o, m_score);
      else n_pass++;
    end
    n_checks++;
    if (ox[0] !== 11'd638) $display("FAIL wrap_x0: got %0d exp 638", ox[0]);
    else n_pass++;
    n_checks++;
    if (ox[1] !== 11'd158) $display("FAIL wrap_x1: got %0d exp 158", ox[1]);
    else n_pass++;
    n_checks++;
    if (int'(ox[0]) - int'(ox[1]) !== 480) $display("FAIL wrap_spacing: got %0d exp 480", int'(ox[0]) - int'(ox[1]));
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (oy[k] !== m_y[k]) $display("FAIL wrap_y%0d: got %0d exp %0d", k, oy[k], m_y[k]);
      else n_pass++;
    end
  endtask

  task automatic test_collide();
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ox[k] !== 11'(pos(k, 321))) $display("FAIL collide_x%0d: got %0d exp %0d", k, ox[k], pos(k, 321));
      else n_pass++;
    end
    n_checks++;
    if (bus.score_o !== 1'b0 || bus.running_o !== 1'b0)
      $display("FAIL collide_flags: score %b running %b exp 0 0", bus.score_o, bus.running_o);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ox[k] !== 11'(pos(k, 321)) || oy[k] !== m_y[k])
          $display("FAIL halt_frozen%0d: got x %0d y %0d exp x %0d y %0d", k, ox[k], oy[k], pos(k, 321), m_y[k]);
        else n_pass++;
      end
      n_checks++;
      if (bus.score_o !== 1'b0 || bus.running_o !== 1'b0 || bus.rom_idx_o !== m_lfsr[1:0])
        $display("FAIL halt_flags: score %b running %b idx %0d exp 0 0 %0d", bus.score_o, bus.running_o, bus.rom_idx_o, m_lfsr[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ox[k] !== 11'(X0 + k * SPACING)) $display("FAIL restart_x%0d: got %0d exp %0d", k, ox[k], X0 + k * SPACING);
      else n_pass++;
      n_checks++;
      if (oy[k] !== rom_h(m_lfsr[1:0] + 2'(k))) $display("FAIL restart_y%0d: got %0d exp %0d", k, oy[k], rom_h(m_lfsr[1:0] + 2'(k)));
      else n_pass++;
    end
    n_checks++;
    if (bus.running_o !== 1'b0 || bus.rom_idx_o !== m_lfsr[1:0])
      $display("FAIL restart_flags: running %b idx %0d exp 0 %0d", bus.running_o, bus.rom_idx_o, m_lfsr[1:0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic tick;
    logic collide;
    logic start;
    for (int c = 0; c < 1500; c++) begin
      tick    = ($urandom_range(0, 9) < 8);
      collide = ($urandom_range(0, 999) == 0);
      start   = ($urandom_range(0, 39) == 0);
      cycle(tick, collide, start);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ox[k] !== 11'(pos(k, m_ticks))) $display("FAIL rand_x%0d cyc %0d: got %0d exp %0d", k, c, ox[k], pos(k, m_ticks));
        else n_pass++;
        n_checks++;
        if (oy[k] !== m_y[k]) $display("FAIL rand_y%0d cyc %0d: got %0d exp %0d", k, c, oy[k], m_y[k]);
        else n_pass++;
      end
      n_checks++;
      if (bus.score_o !== m_score) $display("FAIL rand_score cyc %0d: got %b exp %b", c, bus.score_o, m_score);
      else n_pass++;
      n_checks++;
      if (bus.running_o !== (m_state == M_RUN)) $display("FAIL rand_running cyc %0d: got %b exp %b", c, bus.running_o, m_state == M_RUN);
      else n_pass++;
      n_checks++;
      if (bus.rom_idx_o !== m_lfsr[1:0]) $display("FAIL rand_idx cyc %0d: got %0d exp %0d", c, bus.rom_idx_o, m_lfsr[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    if (m_state == M_HALT) cycle(1'b0, 1'b0, 1'b1);
    if (m_state == M_IDLE) cycle(1'b0, 1'b0, 1'b1);
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.running_o !== 1'b1) $display("FAIL arst_pre_running: got %b exp 1", bus.running_o);
    else n_pass++;
    #3;
    bus.frame_tick_i = 1'b1;
    Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ox[k] !== 11'(X0 + k * SPACING) || oy[k] !== 10'd0)
        $display("FAIL arst_pipe%0d: got x %0d y %0d exp x %0d y 0", k, ox[k], oy[k], X0 + k * SPACING);
      else n_pass++;
    end
    n_checks++;
    if (bus.score_o !== 1'b0 || bus.running_o !== 1'b0 || bus.rom_idx_o !== 2'b01)
      $display("FAIL arst_flags: score %b running %b idx %0d exp 0 0 1", bus.score_o, bus.running_o, bus.rom_idx_o);
    else n_pass++;
    bus.frame_tick_i = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (oy[0] !== 10'd150) $display("FAIL arst_reload_y0: got %0d exp 150", oy[0]);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scroll();
    test_wrap();
    test_collide();
    test_restart();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Obstacle manager that sits directly downstream of the pipe-height ROM.
- Drives the ROM index, latches the returned top-edge heights, and scrolls four pipes leftward once per frame tick.
- Respawns each pipe at the right when it leaves the screen and pulses a score strobe when a pipe clears the bird.
- Outputs feed the VGA renderer and the collision logic.

Parameters:
- X0, 640: left-edge X of pipe 0 at layout load.
- SPACING, 160: horizontal pitch between consecutive pipes.
- SPEED, 2: pixels moved per frame tick; must be less than SPACING.
- PIPE_W, 40: pipe width in pixels.
- BIRD_X, 160: bird X column used for scoring.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_tick_i, in, 1: one-cycle pulse per video frame.
- start_i, in, 1: start or restart request, level-sampled.
- collide_i, in, 1: collision flag from collision logic.
- rom_idx_o, out, 2: index to the height ROM.
- rom_y0_i .. rom_y3_i, in, 10 each: ROM outputs (primary, edge1, edge2, edge3); combinational path.
- pipe_x0_o .. pipe_x3_o, out, 11 each: pipe left-edge X.
- pipe_y0_o .. pipe_y3_o, out, 10 each: pipe top-edge Y.
- score_o, out, 1: one-cycle pulse per pipe passed.
- running_o, out, 1: high in RUN.

Behaviour:
- Single clock Clk; reset Reset_n is asynchronous, active-low.
- Reset values:
  - state IDLE; lfsr = LFSR_SEED.
  - pipe_xk = X0 + k*SPACING, giving 640/800/960/1120.
  - pipe_yk = 0; score_o = 0; running_o = 0.
- rom_idx_o = lfsr[1:0], combinational from register. The ROM is combinational, so the heights it returns are valid in the same cycle.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every clock in RUN only; frozen in IDLE and HALT.
- State IDLE:
  - Every clock, latch pipe_y0..3 <= rom_y0..3_i and reload the X layout.
  - start_i -> RUN.
- State RUN, on frame_tick_i with collide_i low, for each pipe k:
  - If pipe_xk >= SPEED: pipe_xk <= pipe_xk - SPEED.
  - Else (wrap): pipe_xk <= pipe_xk + 4*SPACING - SPEED and pipe_yk <= rom_y0_i.
  - Pipe spacing is preserved exactly across a wrap.
- Wrap rules:
  - At most one pipe wraps per tick, guaranteed by SPEED < SPACING.
  - Height for a wrapping pipe is taken from the ROM index current in that cycle.
- Score:
  - score_o = 1 for one cycle on a tick where old pipe_xk + PIPE_W >= BIRD_X and new pipe_xk + PIPE_W < BIRD_X, for any k.
  - Evaluated only on non-wrap moves.
  - Comparisons use 12-bit arithmetic, no overflow.
- RUN with collide_i high:
  - -> HALT in the next cycle. collide_i beats frame_tick_i in the same cycle: no movement, no score.
  - start_i is ignored in RUN.
- State HALT:
  - Positions and heights frozen.
  - start_i -> IDLE, which reloads the layout and heights.
  - collide_i is ignored.
- Without a frame_tick_i pulse, nothing moves in any state.
- Reset_n asserted mid-frame or mid-wrap: immediately restore all reset values, with no partial update.
- running_o is registered and equals (state == RUN).

Decomposition:
- Shared package holds:
  - Screen constants: SCREEN_W=640, coordinate widths X_W=11, Y_W=10.
  - Default pipe geometry constants.
  - State encoding IDLE=2'd0, RUN=2'd1, HALT=2'd2.
- Natural sub-module: lfsr8, an 8-bit enabled LFSR with seed parameter, reused by other random sources.
- The height ROM stays external; this block only drives its index.

Test Plan:
- Reset then 2 clocks in IDLE with the height ROM attached (seed A5, idx=01) -> pipe_y = 150/200/250/100; pipe_x = 640/800/960/1120; running_o = 0.
- start_i, then 261 frame ticks -> pipe_x0 = 118 and score_o pulses exactly once, on tick 261; no other score pulse before it.
- Continue to tick 321 -> pipe_x0 wraps 0 -> 638; pipe_x1 = 158; pipe_y0 = ROM primary value for the current rom_idx_o; spacing 480 to pipe_x1 preserved.
- collide_i and frame_tick_i asserted in the same cycle -> no X change, no score; running_o falls the next cycle; further ticks leave all outputs frozen.
- In HALT, pulse start_i -> IDLE; layout back to 640/800/960/1120 and heights reloaded from the ROM at the frozen LFSR index.
- Assert Reset_n low asynchronously between clock edges during RUN -> all outputs take reset values immediately, before the next Clk edge.
